park_transform: RTL and testbench

- Forward Park transform: rotates a stationary-frame vector (alpha, beta) into the rotating frame (d, q) using angle theta.
- Sits on the measurement side of the control loop, feeding current/voltage feedback to the dq regulators.
- Sin/cos come from an external shared trigonometric lookup through a start/valid port pair, so one table can be time-shared.
- Streams one transaction at a time, with valid/ready handshakes on both sides and a timeout on the trig lookup.

---
 rtl/park_transform.sv | 170 +++++++++++++++++
 tb/tb_park_transform.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_transform.sv
// Forward Park transform (alpha,beta) -> (d,q) using an external, shared sin/cos lookup.
// Build option: define PARK_SATURATION_EN to clamp d/q to 18 bits instead of wrapping.
module park_transform #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int OUTPUT_SHIFT   = 17
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] theta,
    input  logic [17:0] alpha,
    input  logic [17:0] beta,
    output logic        trig_start,
    output logic [15:0] trig_theta,
    input  logic [15:0] sin_in,
    input  logic [15:0] cos_in,
    input  logic        trig_valid,
    output logic [17:0] d,
    output logic [17:0] q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        trig_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_MULT,
        S_SUM,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic        [7:0]  r_cnt;
    logic               w_timeout;
    logic signed [17:0] r_alpha;
    logic signed [17:0] r_beta;
    logic signed [15:0] r_sin;
    logic signed [15:0] r_cos;
    logic signed [17:0] w_s;
    logic signed [17:0] w_c;
    logic signed [35:0] r_p_ac;
    logic signed [35:0] r_p_bs;
    logic signed [35:0] r_p_as;
    logic signed [35:0] r_p_bc;
    logic signed [36:0] w_d_full;
    logic signed [36:0] w_q_full;
    logic signed [36:0] w_d_shift;
    logic signed [36:0] w_q_shift;
    logic        [17:0] r_d;
    logic        [17:0] r_q;
    logic               r_out_valid;
    logic               r_trig_start;
    logic               r_trig_timeout;
    logic        [15:0] r_trig_theta;

    // Q1.15 trig scaled to 18 bits so products land in Q.17 alongside the 18-bit inputs
    assign w_s = {r_sin, 2'b00};
    assign w_c = {r_cos, 2'b00};

    assign w_d_full  = 37'(r_p_ac) + 37'(r_p_bs);
    assign w_q_full  = 37'(r_p_bc) - 37'(r_p_as);
    assign w_d_shift = w_d_full >>> OUTPUT_SHIFT;
    assign w_q_shift = w_q_full >>> OUTPUT_SHIFT;

`ifdef PARK_SATURATION_EN
    function automatic logic [17:0] fit18(input logic signed [36:0] v);
        if (v > 37'sd131071)
            return 18'h1FFFF;
        else if (v < -37'sd131072)
            return 18'h20000;
        else
            return 18'(v);
    endfunction
`else
    function automatic logic [17:0] fit18(input logic signed [36:0] v);
        return 18'(v);
    endfunction
`endif

    // trig_valid has priority over an expiring timeout on the same edge
    assign w_timeout = (r_state == S_WAIT_TRIG) && !trig_valid &&
                       (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (in_valid) w_next = S_WAIT_TRIG;
            S_WAIT_TRIG: begin
                if (trig_valid)     w_next = S_MULT;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_MULT:      w_next = S_SUM;
            S_SUM:       w_next = S_HOLD;
            S_HOLD:      if (out_ready) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_alpha        <= '0;
            r_beta         <= '0;
            r_sin          <= '0;
            r_cos          <= '0;
            r_p_ac         <= '0;
            r_p_bs         <= '0;
            r_p_as         <= '0;
            r_p_bc         <= '0;
            r_d            <= '0;
            r_q            <= '0;
            r_out_valid    <= 1'b0;
            r_trig_start   <= 1'b0;
            r_trig_timeout <= 1'b0;
            r_trig_theta   <= '0;
        end else begin
            r_trig_start   <= (r_state == S_IDLE) && in_valid;
            r_trig_timeout <= w_timeout;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (in_valid) begin
                        r_alpha      <= alpha;
                        r_beta       <= beta;
                        r_trig_theta <= theta;
                    end
                end
                S_WAIT_TRIG: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (trig_valid) begin
                        r_sin <= sin_in;
                        r_cos <= cos_in;
                    end
                end
                S_MULT: begin
                    r_p_ac <= r_alpha * w_c;
                    r_p_bs <= r_beta  * w_s;
                    r_p_as <= r_alpha * w_s;
                    r_p_bc <= r_beta  * w_c;
                end
                S_SUM: begin
                    r_d         <= fit18(w_d_shift);
                    r_q         <= fit18(w_q_shift);
                    r_out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign trig_start   = r_trig_start;
    assign trig_theta   = r_trig_theta;
    assign trig_timeout = r_trig_timeout;
    assign d            = r_d;
    assign q            = r_q;
    assign out_valid    = r_out_valid;

endmodule

// File: tb/tb_park_transform.sv
// Directed, table-driven bench for park_transform with a scripted trig lookup responder.
// Expected d/q are hand-computed; overflow rows depend on PARK_SATURATION_EN.
module tb_park_transform;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] theta;
    logic [17:0] alpha;
    logic [17:0] beta;
    logic        trig_start;
    logic [15:0] trig_theta;
    logic [15:0] sin_in;
    logic [15:0] cos_in;
    logic        trig_valid;
    logic [17:0] d;
    logic [17:0] q;
    logic        out_valid;
    logic        out_ready;
    logic        trig_timeout;

    park_transform #(
        .TIMEOUT_CYCLES(16),
        .OUTPUT_SHIFT  (17)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .theta       (theta),
        .alpha       (alpha),
        .beta        (beta),
        .trig_start  (trig_start),
        .trig_theta  (trig_theta),
        .sin_in      (sin_in),
        .cos_in      (cos_in),
        .trig_valid  (trig_valid),
        .d           (d),
        .q           (q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .trig_timeout(trig_timeout)
    );

`ifdef PARK_SATURATION_EN
    localparam int OVF_D = 131071;
    localparam int BIG_D = 131071;
`else
    localparam int OVF_D = -10;
    localparam int BIG_D = 0;
`endif

    typedef struct {
        logic [15:0]        th;
        logic signed [17:0] a;
        logic signed [17:0] b;
        logic signed [15:0] s;
        logic signed [15:0] c;
        int                 ed;
        int                 eq;
    } vec_t;

    vec_t vt[9];
    int   n_vec;
    int   n_bad;
    int   n_start;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (trig_start === 1'b1) n_start <= n_start + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Full transaction: trig responds two cycles after trig_start; optional output backpressure.
    task automatic run_vec(input vec_t v, input string tag, input int hold);
        int    k;
        int    ts0;
        bit    stable;
        logic [17:0] d0;
        logic [17:0] q0;
        ts0      = n_start;
        theta    = v.th;
        alpha    = v.a;
        beta     = v.b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        alpha    = '0;
        beta     = '0;
        check({tag, " trig_start"}, 32'(trig_start), 1);
        check({tag, " trig_theta"}, 32'(trig_theta), 32'(v.th));
        tick();
        tick();
        sin_in     = v.s;
        cos_in     = v.c;
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        sin_in     = '0;
        cos_in     = '0;
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check({tag, " latency"}, k, 2);
        check({tag, " d"}, 32'($signed(d)), v.ed);
        check({tag, " q"}, 32'($signed(q)), v.eq);
        check({tag, " start_pulses"}, n_start - ts0, 1);
        if (hold > 0) begin
            stable = 1'b1;
            d0 = d;
            q0 = q;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== d0 || q !== q0)
                    stable = 1'b0;
            end
            check({tag, " hold_stable"}, 32'(stable), 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(out_valid), 0);
        check({tag, " in_ready_idle"}, 32'(in_ready), 1);
    endtask

    initial begin
        int          k;
        bit          quiet;
        logic [17:0] d_prev;
        logic [17:0] q_prev;

        n_vec = 0;
        n_bad = 0;
        n_start = 0;

        //       theta     alpha            beta             sin            cos           d      q
        vt[0] = '{16'h0000, 18'sd1000,       18'sd500,        16'sd0,        16'sd32767,   999,   499};
        vt[1] = '{16'h4000, 18'sd1000,       18'sd500,        16'sd32767,    16'sd0,       499,   -1000};
        vt[2] = '{16'h2000, 18'sd131071,     18'sd131071,     16'sd32767,    16'sd32767,   OVF_D, 0};
        vt[3] = '{16'h8000, -18'sd1000,      18'sd0,          16'sd0,        16'sd32767,   -1000, 0};
        vt[4] = '{16'hC000, 18'sd1000,       18'sd500,        16'sh8000,     16'sd0,       -500,  1000};
        vt[5] = '{16'h1555, 18'sd1000,       18'sd500,        16'sd16384,    16'sd16384,   750,   -250};
        vt[6] = '{16'hA000, 18'sh20000,      18'sh20000,      16'sh8000,     16'sh8000,    BIG_D, 0};
        vt[7] = '{16'h1234, 18'sd0,          18'sd0,          16'sd12345,    -16'sd5000,   0,     0};
        vt[8] = '{16'hFFFF, 18'sd3,          -18'sd3,         16'sd0,        16'sd32767,   2,     -3};

        reset      = 1'b0;
        in_valid   = 1'b0;
        theta      = '0;
        alpha      = '0;
        beta       = '0;
        sin_in     = '0;
        cos_in     = '0;
        trig_valid = 1'b0;
        out_ready  = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();

        check("reset d", 32'($signed(d)), 0);
        check("reset q", 32'($signed(q)), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset in_ready", 32'(in_ready), 1);
        check("reset trig_start", 32'(trig_start), 0);
        check("reset trig_theta", 32'(trig_theta), 0);
        check("reset trig_timeout", 32'(trig_timeout), 0);

        for (int i = 0; i < 9; i++)
            run_vec(vt[i], $sformatf("vec%0d", i), 0);

        run_vec(vt[5], "backpressure", 10);

        // Timeout: never answer the lookup
        d_prev   = d;
        q_prev   = q;
        theta    = 16'h0777;
        alpha    = 18'sd77;
        beta     = 18'sd88;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (trig_timeout !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("timeout cycles", k, 16);
        check("timeout in_ready", 32'(in_ready), 1);
        check("timeout out_valid", 32'(out_valid), 0);
        check("timeout d_kept", 32'(d), 32'(d_prev));
        check("timeout q_kept", 32'(q), 32'(q_prev));
        tick();
        check("timeout pulse_once", 32'(trig_timeout), 0);
        sin_in     = 16'sd16384;
        cos_in     = 16'sd16384;
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || trig_start !== 1'b0) quiet = 1'b0;
            tick();
        end
        check("late trig_valid ignored", 32'(quiet), 1);
        check("late d_kept", 32'(d), 32'(d_prev));

        // Reset while in MULT
        theta    = 16'h0100;
        alpha    = 18'sd2000;
        beta     = 18'sd1000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        sin_in     = 16'sd0;
        cos_in     = 16'sd32767;
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset out_valid", 32'(out_valid), 0);
        check("midreset d", 32'($signed(d)), 0);
        check("midreset q", 32'($signed(q)), 0);
        check("midreset in_ready", 32'(in_ready), 1);
        check("midreset trig_theta", 32'(trig_theta), 0);
        repeat (3) tick();
        check("midreset no out", 32'(out_valid), 0);

        run_vec(vt[0], "after_reset", 0);
        run_vec(vt[1], "after_reset2", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
